lsu_bridge: RTL and testbench
=============================

Name: lsu_bridge

Overview:
- Memory-stage load/store unit between the pipelined RV32I core and the data-memory bus (valid/ready request, rvalid response).
- Issues the bus transaction for the instruction in M, aligns store data and byte strobes, and extracts and extends load data.
- Drives stall_m back into hazard control, so the frozen pipeline waits for multi-cycle memory.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, maximum cycles in REQ+WAIT_R before abort (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- memread_m  in  1  load in M stage
- memwrite_m  in  1  store in M stage
- funct3_m  in  3  access size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101; stores use 000/001/010)
- addr_m  in  ADDR_W  byte address from ALU
- wdata_m  in  32  store data (rs2, forwarded)
- stall_m  out  1  freeze F/D/E/M while a request is outstanding
- err_m  out  1  one-cycle pulse: misaligned or illegal access, or timeout
- rdata_m  out  32  extended load result, valid in the DONE cycle
- bus_valid  out  1  request valid
- bus_ready  in  1  request accepted
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address (addr_m with [1:0] = 0)
- bus_wstrb  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read word

Behaviour:
- States: IDLE, REQ, WAIT_R, DONE.
- Reset values: state IDLE; bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata all 0; rdata_m 0; err_m 0. Reset mid-transaction drops bus_valid immediately and returns to IDLE.
- IDLE:
  - If (memread_m|memwrite_m) and the access is legal: stall_m=1 combinationally; register the bus fields; go to REQ.
  - If the access is illegal or misaligned: err_m=1 for that cycle, stall_m=0, no bus activity, stay IDLE.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- Illegal: funct3 011/110/111; memread_m and memwrite_m both set.
- REQ:
  - bus_valid=1, stall_m=1.
  - Fields are held stable until the bus_valid&bus_ready handshake.
  - On handshake: store goes to DONE; load goes to WAIT_R.
  - bus_rvalid is ignored in REQ; the earliest legal rvalid is the cycle after acceptance.
- WAIT_R: bus_valid=0, stall_m=1. On bus_rvalid, register the extracted result into rdata_m and go to DONE.
- DONE: stall_m=0 so the pipeline advances this cycle; rdata_m is valid; unconditionally go to IDLE.
- Back-to-back memory ops: the next instruction is seen in IDLE on the cycle after DONE.
- Minimum stall: store 2 cycles (IDLE, REQ with ready=1); load 3 cycles (IDLE, REQ, WAIT_R with rvalid).
- Store strobes/data:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{b}}.
  - SH: wstrb = 0011 << (2*addr[1]), wdata = {2{h}}.
  - SW: wstrb = 1111.
- Load extract: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- The M-stage instruction is never flushed, so there is no flush input. M-stage inputs are stable while stall_m=1, and the bridge captures them at IDLE exit.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- With LSU_TIMEOUT_EN:
  - An 8+-bit counter (sized from TIMEOUT) clears on IDLE exit and increments each cycle in REQ/WAIT_R.
  - On reaching TIMEOUT: drop bus_valid, go to DONE, pulse err_m, set rdata_m=0.
- Without LSU_TIMEOUT_EN: no counter; the bridge waits indefinitely.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B/H/W/BU/HU)
  - state enum typedef
  - function wstrb_gen(funct3, addr[1:0])
- Sub-module load_align: combinational, takes bus_rdata, addr[1:0] and funct3, and outputs the 32-bit extended result. It is reused by the later cache path.

Test Plan:
- SW 0xDEADBEEF @0x100, ready on the first REQ cycle → bus_addr 0x100, wstrb 1111, 2 stall cycles, no err.
- SB 0xA5 @0x203 → bus_addr 0x200, wstrb 1000, wdata 0xA5A5A5A5.
- LB @0x101 with rdata 0x0080FF00, rvalid 1 cycle after accept → rdata_m 0xFFFFFFFF in DONE. LBU at the same address → 0x000000FF.
- LH @0x102, ready delayed 3 cycles, rdata 0x8001xxxx → bus fields stable throughout; rdata_m 0xFFFF8001; 6 stall cycles.
- LW @0x106 → err_m pulse, no bus_valid, stall_m never asserted. funct3=011 → same.
- rst_n low during WAIT_R → bus_valid 0, state IDLE, outputs reset; a later LW completes normally. With LSU_TIMEOUT_EN and TIMEOUT=4, ready held low → abort after 4 cycles with err_m=1 and rdata_m=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store bridge: access-size codes,
// FSM state encoding and the store byte-strobe generator.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_R,
    ST_DONE
  } lsu_state_e;

  // Byte lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] wstrb_gen(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (funct3)
      F3_B, F3_BU: strb = 4'b0001 << addr_lo;
      F3_H, F3_HU: strb = 4'b0011 << {addr_lo[1], 1'b0};
      default:     strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a bus read word and sign- or
// zero-extends it according to the load size code.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bridge.sv
// Memory-stage load/store bridge: issues one bus transaction per M-stage access
// and stalls the pipeline until it completes. Optional abort timer: LSU_TIMEOUT_EN.
module lsu_bridge
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread_m,
  input  logic              memwrite_m,
  input  logic [2:0]        funct3_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [31:0]       wdata_m,
  output logic              stall_m,
  output logic              err_m,
  output logic [31:0]       rdata_m,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  lsu_state_e        state_q, state_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;

  logic        access, illegal, misaligned, err_idle;
  logic [31:0] store_data;
  logic [31:0] load_result;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  load_align u_load_align (
    .rdata   (bus_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .result  (load_result)
  );

  always_comb begin
    access     = memread_m | memwrite_m;
    illegal    = (memread_m & memwrite_m) |
                 (funct3_m == 3'b011) | (funct3_m == 3'b110) | (funct3_m == 3'b111);
    misaligned = ((funct3_m[1:0] == 2'b01) & addr_m[0]) |
                 ((funct3_m[1:0] == 2'b10) & (addr_m[1:0] != 2'b00));
    case (funct3_m[1:0])
      2'b00:   store_data = {4{wdata_m[7:0]}};
      2'b01:   store_data = {2{wdata_m[15:0]}};
      default: store_data = wdata_m;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    stall_m     = 1'b0;
    err_idle    = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (illegal | misaligned) begin
            err_idle = 1'b1;
          end else begin
            stall_m     = 1'b1;
            state_d     = ST_REQ;
            bus_valid_d = 1'b1;
            bus_we_d    = memwrite_m;
            bus_addr_d  = {addr_m[ADDR_W-1:2], 2'b00};
            bus_wstrb_d = memwrite_m ? wstrb_gen(funct3_m, addr_m[1:0]) : 4'b0000;
            bus_wdata_d = memwrite_m ? store_data : 32'd0;
            funct3_d    = funct3_m;
            addr_lo_d   = addr_m[1:0];
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      ST_REQ: begin
        stall_m = 1'b1;
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          state_d     = bus_we_q ? ST_DONE : ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        stall_m = 1'b1;
        if (bus_rvalid) begin
          rdata_d = load_result;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef LSU_TIMEOUT_EN
    // A handshake or response landing on the final cycle still wins over the abort.
    if ((state_q == ST_REQ) || (state_q == ST_WAIT_R)) begin
      cnt_d = cnt_q + 1'b1;
      if ((state_d == state_q) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
        bus_valid_d = 1'b0;
        state_d     = ST_DONE;
        err_d       = 1'b1;
        rdata_d     = 32'd0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= 4'b0000;
      bus_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign rdata_m   = rdata_q;
  // Illegal accesses flag in IDLE itself; timeouts flag in the DONE cycle.
  assign err_m     = err_idle | err_q;

endmodule

// File: tb/tb_lsu_bridge.sv
// Scoreboard bench for lsu_bridge: expected transactions are queued at stimulus
// time and compared against observed bus/pipeline behaviour.
module tb_lsu_bridge;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread_m = 1'b0, memwrite_m = 1'b0;
  logic [2:0]  funct3_m = 3'b000;
  logic [31:0] addr_m = 32'd0, wdata_m = 32'd0;
  logic        stall_m, err_m;
  logic [31:0] rdata_m;
  logic        bus_valid, bus_we;
  logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata = 32'd0;

  lsu_bridge #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .memread_m(memread_m), .memwrite_m(memwrite_m),
    .funct3_m(funct3_m), .addr_m(addr_m), .wdata_m(wdata_m), .stall_m(stall_m),
    .err_m(err_m), .rdata_m(rdata_m), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    logic        saw_valid;
    logic        stable;
    logic        to;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Presents one access at the current negedge and plays the bus slave.
  // Returns at the negedge after the non-stalled (DONE or error) cycle, inputs left asserted.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int rdy_dly, input logic [31:0] rword);
    txn_t o;
    int   req_n;
    bit   done;
    o = '{we: 1'b0, addr: 32'd0, wstrb: 4'd0, wdata: 32'd0, rdata: 32'd0, err: 1'b0,
          stalls: 0, saw_valid: 1'b0, stable: 1'b1, to: 1'b0};
    memread_m = rd; memwrite_m = wr; funct3_m = f3; addr_m = addr; wdata_m = wd;
    req_n = 0;
    done  = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      #1;
      if (err_m) o.err = 1'b1;
      if (stall_m) o.stalls++;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      if (bus_valid) begin
        if (!o.saw_valid) begin
          o.saw_valid = 1'b1;
          o.we = bus_we; o.addr = bus_addr; o.wstrb = bus_wstrb; o.wdata = bus_wdata;
        end else if ({bus_we, bus_addr, bus_wstrb, bus_wdata} !== {o.we, o.addr, o.wstrb, o.wdata}) begin
          o.stable = 1'b0;
        end
        bus_ready = (req_n >= rdy_dly);
        req_n++;
      end else if (o.saw_valid && stall_m) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rword;
      end
      if (!stall_m) begin
        done    = 1;
        o.rdata = rdata_m;
      end
      @(negedge clk);
    end
    if (!done) o.to = 1'b1;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    obs_q.push_back(o);
  endtask

  task automatic idle_inputs();
    memread_m = 1'b0; memwrite_m = 1'b0; funct3_m = 3'b000; addr_m = 32'd0; wdata_m = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got valid=%b we=%b wstrb=%h addr=%h wdata=%h, want all 0",
               bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata);
    end
    n_tests++;
    if ({rdata_m, err_m, stall_m} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_core: got rdata=%h err=%b stall=%b, want 0", rdata_m, err_m, stall_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Stores issued back-to-back; expected lanes/data from an independent byte-lane model.
  task automatic test_stores();
    logic [2:0]  f3s [4] = '{3'b010, 3'b000, 3'b001, 3'b000};
    logic [31:0] ads [4] = '{32'h100, 32'h203, 32'h302, 32'h001};
    logic [31:0] wds [4] = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234, 32'hFFFFFF5A};
    int          rdy [4] = '{0, 0, 2, 1};
    for (int i = 0; i < 4; i++) begin
      txn_t e;
      logic [31:0] wd;
      wd = wds[i];
      e = '{we: 1'b1, addr: ads[i] & 32'hFFFF_FFFC, wstrb: 4'd0, wdata: 32'd0, rdata: 32'd0,
            err: 1'b0, stalls: 2 + rdy[i], saw_valid: 1'b1, stable: 1'b1, to: 1'b0};
      if (f3s[i] == 3'b000) begin
        e.wstrb = 4'b0001 << ads[i][1:0];
        e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      end else if (f3s[i] == 3'b001) begin
        e.wstrb = ads[i][1] ? 4'b1100 : 4'b0011;
        e.wdata = {wd[15:0], wd[15:0]};
      end else begin
        e.wstrb = 4'b1111;
        e.wdata = wd;
      end
      exp_q.push_back(e);
      run_access(1'b0, 1'b1, f3s[i], ads[i], wds[i], rdy[i], 32'd0);
    end
    idle_inputs();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      txn_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      $display("[TB] store addr=%h wstrb=%b wdata=%h stalls=%0d", o.addr, o.wstrb, o.wdata, o.stalls);
      n_tests++;
      if (o.addr !== e.addr) begin n_fail++; $display("FAIL st_addr: got %h want %h", o.addr, e.addr); end
      n_tests++;
      if (o.wstrb !== e.wstrb) begin n_fail++; $display("FAIL st_wstrb: got %b want %b", o.wstrb, e.wstrb); end
      n_tests++;
      if (o.wdata !== e.wdata) begin n_fail++; $display("FAIL st_wdata: got %h want %h", o.wdata, e.wdata); end
      n_tests++;
      if (o.stalls != e.stalls) begin n_fail++; $display("FAIL st_stalls: got %0d want %0d", o.stalls, e.stalls); end
      n_tests++;
      if ({o.we, o.err, o.saw_valid, o.stable, o.to} !== {e.we, e.err, e.saw_valid, e.stable, e.to}) begin
        n_fail++;
        $display("FAIL st_flags: got we/err/valid/stable/to=%b%b%b%b%b want %b%b%b%b%b",
                 o.we, o.err, o.saw_valid, o.stable, o.to, e.we, e.err, e.saw_valid, e.stable, e.to);
      end
    end
  endtask

  // Loads with hand-derived extraction results.
  task automatic test_loads();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ads [5] = '{32'h101, 32'h101, 32'h102, 32'h100, 32'h040};
    logic [31:0] rws [5] = '{32'h0080FF00, 32'h0080FF00, 32'h80015555, 32'h1234F00D, 32'h12345678};
    logic [31:0] res [5] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8001, 32'h0000F00D, 32'h12345678};
    int          rdy [5] = '{0, 0, 3, 1, 0};
    for (int i = 0; i < 5; i++) begin
      txn_t e;
      e = '{we: 1'b0, addr: ads[i] & 32'hFFFF_FFFC, wstrb: 4'd0, wdata: 32'd0, rdata: res[i],
            err: 1'b0, stalls: 3 + rdy[i], saw_valid: 1'b1, stable: 1'b1, to: 1'b0};
      exp_q.push_back(e);
      run_access(1'b1, 1'b0, f3s[i], ads[i], 32'd0, rdy[i], rws[i]);
    end
    idle_inputs();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      txn_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      $display("[TB] load addr=%h rdata=%h stalls=%0d", o.addr, o.rdata, o.stalls);
      n_tests++;
      if (o.addr !== e.addr) begin n_fail++; $display("FAIL ld_addr: got %h want %h", o.addr, e.addr); end
      n_tests++;
      if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL ld_rdata: got %h want %h", o.rdata, e.rdata); end
      n_tests++;
      if (o.stalls != e.stalls) begin n_fail++; $display("FAIL ld_stalls: got %0d want %0d", o.stalls, e.stalls); end
      n_tests++;
      if ({o.we, o.err, o.saw_valid, o.stable, o.to} !== {e.we, e.err, e.saw_valid, e.stable, e.to}) begin
        n_fail++;
        $display("FAIL ld_flags: got we/err/valid/stable/to=%b%b%b%b%b want %b%b%b%b%b",
                 o.we, o.err, o.saw_valid, o.stable, o.to, e.we, e.err, e.saw_valid, e.stable, e.to);
      end
    end
  endtask

  // Misaligned and illegal accesses: error pulse, no stall, no bus request.
  task automatic test_errors();
    logic        rds [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        wrs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b010, 3'b001};
    logic [31:0] ads [4] = '{32'h106, 32'h100, 32'h100, 32'h101};
    for (int i = 0; i < 4; i++) begin
      run_access(rds[i], wrs[i], f3s[i], ads[i], 32'h11223344, 0, 32'd0);
    end
    idle_inputs();
    while (obs_q.size() > 0) begin
      txn_t o;
      o = obs_q.pop_front();
      $display("[TB] error-case err=%b stalls=%0d valid=%b", o.err, o.stalls, o.saw_valid);
      n_tests++;
      if ({o.err, o.saw_valid, o.to} !== 3'b100 || o.stalls != 0) begin
        n_fail++;
        $display("FAIL err_access: got err=%b valid=%b to=%b stalls=%0d want err=1 valid=0 to=0 stalls=0",
                 o.err, o.saw_valid, o.to, o.stalls);
      end
    end
  endtask

  task automatic test_reset_mid();
    txn_t e, o;
    memread_m = 1'b1; funct3_m = 3'b010; addr_m = 32'h80;
    @(negedge clk);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    n_tests++;
    if ({bus_valid, stall_m} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_wait_r: got valid=%b stall=%b want valid=0 stall=1", bus_valid, stall_m);
    end
    memread_m = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata, rdata_m, err_m, stall_m} !== 104'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b addr=%h rdata=%h err=%b stall=%b want all 0",
               bus_valid, bus_addr, rdata_m, err_m, stall_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e = '{we: 1'b0, addr: 32'h84, wstrb: 4'd0, wdata: 32'd0, rdata: 32'hCAFEF00D, err: 1'b0,
          stalls: 3, saw_valid: 1'b1, stable: 1'b1, to: 1'b0};
    exp_q.push_back(e);
    run_access(1'b1, 1'b0, 3'b010, 32'h84, 32'd0, 0, 32'hCAFEF00D);
    idle_inputs();
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    $display("[TB] post-reset load addr=%h rdata=%h stalls=%0d", o.addr, o.rdata, o.stalls);
    n_tests++;
    if (o.rdata !== e.rdata || o.addr !== e.addr || o.stalls != e.stalls || o.err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_lw: got addr=%h rdata=%h stalls=%0d err=%b want addr=%h rdata=%h stalls=%0d err=0",
               o.addr, o.rdata, o.stalls, o.err, e.addr, e.rdata, e.stalls);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    txn_t o;
    run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 1000, 32'd0);
    idle_inputs();
    o = obs_q.pop_front();
    $display("[TB] timeout err=%b rdata=%h stalls=%0d", o.err, o.rdata, o.stalls);
    n_tests++;
    if (o.err !== 1'b1 || o.rdata !== 32'd0 || o.stalls != 1 + TO || o.to !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: got err=%b rdata=%h stalls=%0d hung=%b want err=1 rdata=0 stalls=%0d hung=0",
               o.err, o.rdata, o.stalls, o.to, 1 + TO);
    end
    n_tests++;
    if (bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_valid: got %b want 0", bus_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_errors();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
